// File: rtl/seg_pkg.sv
// Shared glyph codes, segment patterns and conversion FSM states for the
// multiplexed seven-segment display scanner.
package seg_pkg;

  typedef logic [3:0] glyph_t;

  localparam glyph_t GLYPH_DASH  = 4'd10;
  localparam glyph_t GLYPH_BLANK = 4'd11;

  // Active-low segments, bit0 = a ... bit6 = g
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_COMMIT = 2'd2
  } conv_state_t;

  function automatic logic [6:0] glyph_to_seg(glyph_t g);
    case (g)
      4'd0:        return SEG_0;
      4'd1:        return SEG_1;
      4'd2:        return SEG_2;
      4'd3:        return SEG_3;
      4'd4:        return SEG_4;
      4'd5:        return SEG_5;
      4'd6:        return SEG_6;
      4'd7:        return SEG_7;
      4'd8:        return SEG_8;
      4'd9:        return SEG_9;
      GLYPH_DASH:  return SEG_DASH;
      default:     return SEG_BLANK;
    endcase
  endfunction

  // Largest magnitude that fits in the n_dig-1 numeric positions
  function automatic int unsigned capacity(int n_dig);
    int unsigned r;
    r = 1;
    for (int i = 0; i < n_dig - 1; i++) r = r * 10;
    return r - 1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one shift with add-3 correction per cycle,
// W cycles per conversion. Only the lower N_DIG-1 BCD digits are kept;
// truncating the top digits does not disturb the lower ones.
module bin2bcd_seq #(
  parameter int W     = 9,
  parameter int N_DIG = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [W-1:0]             bin,
  output logic                     busy,
  output logic                     done,
  output logic [4*(N_DIG-1)-1:0]   bcd
);

  localparam int BW = 4 * (N_DIG - 1);
  localparam int CW = $clog2(W + 1);

  logic [CW-1:0] cnt;
  logic [W-1:0]  bin_sr;
  logic [BW-1:0] bcd_sr;
  logic [BW-1:0] bcd_adj;

  // Add-3 correction on every digit that is 5 or more before the shift
  always_comb begin
    bcd_adj = bcd_sr;
    for (int d = 0; d < N_DIG - 1; d++) begin
      if (bcd_sr[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd_sr[4*d +: 4] + 4'd3;
    end
  end

  // Load on start, then shift once per cycle until the counter runs out
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      bin_sr <= '0;
      bcd_sr <= '0;
    end else if (cnt == '0) begin
      if (start) begin
        bin_sr <= bin;
        bcd_sr <= '0;
        cnt    <= CW'(W);
      end
    end else begin
      bcd_sr <= {bcd_adj[BW-2:0], bin_sr[W-1]};
      bin_sr <= {bin_sr[W-2:0], 1'b0};
      cnt    <= cnt - CW'(1);
    end
  end

  assign busy = (cnt != '0);
  assign done = (cnt == CW'(1));  // high during the final shift cycle
  assign bcd  = bcd_sr;

endmodule

// File: rtl/seg_display_scan.sv
// Signed number to multiplexed seven-segment display. Conversion runs in the
// background; the scanned display keeps the previous value until commit.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for load; load captures value and starts conversion
// ST_CONV   | double-dabble shifting, W cycles, load ignored
// ST_COMMIT | one cycle; BCD result, sign and ovf copied to display register
module seg_display_scan
  import seg_pkg::*;
#(
  parameter int N_DIG    = 4,
  parameter int W        = 9,
  parameter int SCAN_DIV = 50000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [W-1:0]     value,
  input  logic             blank_lz,
  output logic [6:0]       SSeg,
  output logic [N_DIG-1:0] an,
  output logic             busy,
  output logic             ovf
);

  localparam int          ND  = N_DIG - 1;
  localparam int          BW  = 4 * ND;
  localparam int          PW  = $clog2(SCAN_DIV);
  localparam int          IW  = $clog2(N_DIG);
  localparam int unsigned CAP = capacity(N_DIG);

  conv_state_t   state, next_state;
  logic          start, commit, busy_d;
  logic [W:0]    mag;
  logic          mag_ovf;
  logic          pend_neg, pend_ovf;
  logic          bcd_busy, bcd_done;
  logic [BW-1:0] bcd;
  logic [BW-1:0] disp_bcd;
  logic          disp_neg, disp_ovf;
  logic [PW-1:0] presc;
  logic [IW-1:0] idx;
  logic          wrap;
  logic          all_zero;
  glyph_t        glyphs [N_DIG];

  // Magnitude one bit wider than the input so -2^(W-1) stays representable
  always_comb begin
    mag = {value[W-1], value};
    if (value[W-1]) mag = ~mag + (W+1)'(1);
    mag_ovf = 32'(mag) > CAP;
  end

  bin2bcd_seq #(.W(W), .N_DIG(N_DIG)) u_bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (mag[W-1:0]),
    .busy  (bcd_busy),
    .done  (bcd_done),
    .bcd   (bcd)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (load) next_state = ST_CONV;
      ST_CONV:   if (bcd_done) next_state = ST_COMMIT;
      ST_COMMIT: next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    start  = (state == ST_IDLE) && load && !bcd_busy;
    commit = (state == ST_COMMIT);
    busy_d = (next_state != ST_IDLE);
  end

  // Capture sign/overflow at load; display register changes only on commit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_neg <= 1'b0;
      pend_ovf <= 1'b0;
      disp_bcd <= '0;
      disp_neg <= 1'b0;
      disp_ovf <= 1'b0;
      busy     <= 1'b0;
    end else begin
      busy <= busy_d;
      if (start) begin
        pend_neg <= value[W-1];
        pend_ovf <= mag_ovf;
      end
      if (commit) begin
        disp_bcd <= bcd;
        disp_neg <= pend_neg;
        disp_ovf <= pend_ovf;
      end
    end
  end

  assign ovf = disp_ovf;

  // Per-position glyphs: digits with optional leading-zero blanking, sign slot on top
  always_comb begin
    all_zero = 1'b1;
    for (int p = 0; p < N_DIG; p++) glyphs[p] = GLYPH_BLANK;
    for (int p = ND - 1; p >= 0; p--) begin
      if (disp_bcd[4*p +: 4] != 4'd0) all_zero = 1'b0;
      if (blank_lz && all_zero && p != 0) glyphs[p] = GLYPH_BLANK;
      else                                glyphs[p] = disp_bcd[4*p +: 4];
    end
    glyphs[ND] = disp_neg ? GLYPH_DASH : GLYPH_BLANK;
    if (disp_ovf) begin
      for (int p = 0; p < N_DIG; p++) glyphs[p] = GLYPH_DASH;
    end
  end

  assign wrap = (presc == PW'(SCAN_DIV - 1));

  // Scan: at each prescaler wrap drive the current position, then advance
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= '0;
      an    <= '1;
      SSeg  <= SEG_BLANK;
    end else if (wrap) begin
      presc <= '0;
      idx   <= (idx == IW'(N_DIG - 1)) ? '0 : idx + IW'(1);
      an    <= ~(N_DIG'(1) << idx);
      SSeg  <= glyph_to_seg(glyphs[idx]);
    end else begin
      presc <= presc + PW'(1);
    end
  end

endmodule

// File: doc/seg_display_scan.md
SEG_DISPLAY_SCAN -- requirements
Module: seg_display_scan

Interface
REQ-001 Parameter N_DIG, default 4: digit positions incl. sign position, range 2..8.
REQ-002 Parameter W, default 9: signed two's-complement input width, range 4..16.
REQ-003 Parameter SCAN_DIV, default 50000: clk cycles per digit slot, >=2.
REQ-004 clk  in  1  single system clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 load  in  1  capture request for value; sampled every cycle.
REQ-007 value  in  W  signed number to display.
REQ-008 blank_lz  in  1  1 = suppress leading zeros, sampled continuously.
REQ-009 SSeg  out  7  segments, active-low, bit0=a ... bit6=g, registered.
REQ-010 an  out  N_DIG  digit enables, active-low one-hot, bit0 = rightmost, registered.
REQ-011 busy  out  1  conversion in progress, registered.
REQ-012 ovf  out  1  displayed value exceeds digit capacity, registered.

Function
REQ-013 States IDLE, CONV, COMMIT; load=1 in IDLE captures value and enters CONV next cycle; load ignored in CONV/COMMIT.
REQ-014 Magnitude computed in W+1 bits (|-2^(W-1)| representable); sign = value[W-1].
REQ-015 CONV performs sequential double-dabble, one shift (with add-3 correction) per cycle, exactly W cycles, then COMMIT for 1 cycle, then IDLE.
REQ-016 busy = 1 from cycle after accepted load through COMMIT inclusive (W+1 cycles).
REQ-017 Display register (digits, sign, ovf) updates only in COMMIT; prior value stays shown during conversion.
REQ-018 Capacity C = 10^(N_DIG-1) - 1; magnitude > C sets ovf=1 and all positions show dash (7'b0111111).
REQ-019 Otherwise positions 0..N_DIG-2 show BCD digits; position N_DIG-1 shows dash if negative, else blank (7'b1111111).
REQ-020 blank_lz=1: zero digits above the most significant nonzero digit are blanked; position 0 is never blanked; blank_lz=0: all zeros shown.
REQ-021 Scan prescaler counts 0..SCAN_DIV-1; at wrap the digit index advances, N_DIG-1 wraps to 0.
REQ-022 an and SSeg update one cycle after index change, together; never two anodes low simultaneously.
REQ-023 load asserted in the same cycle as COMMIT is ignored; load in the IDLE cycle after COMMIT is accepted.
REQ-024 Scanning is independent of conversion; conversion does not stall or reset the scan.

Reset
REQ-025 rst_n=0 at a rising edge: state IDLE, busy=0, ovf=0, SSeg=7'b1111111, an all ones, prescaler and index 0, display register = +0.
REQ-026 Reset mid-conversion aborts it; the in-flight value is never committed.
REQ-027 After release, first anode (bit0) asserts one cycle after first prescaler wrap, showing "0".

Structure
REQ-028 Package seg_pkg holds segment constants (digits 0-9, DASH, BLANK), glyph code typedef (4-bit: 0-9, 10=dash, 11=blank) and glyph-to-segment function.
REQ-029 Sub-module bin2bcd_seq (start, bin, busy, done, bcd digits; parametrised on W and N_DIG) implements REQ-015; scan, blanking, sign and overflow logic stay in the top.

Verification
REQ-030 Defaults, load value=9'sd123 -> busy 10 cycles, then an scan shows 3,2,1,blank; ovf=0.
REQ-031 value=-9'sd45, blank_lz=1 -> positions 5,4,blank,dash; blank_lz=0 -> 5,4,0,dash.
REQ-032 value=-9'sd256 -> magnitude 256, shows 6,5,2,dash, ovf=0; N_DIG=3 same value -> all dashes, ovf=1.
REQ-033 load pulsed every cycle during CONV with different values -> only first value committed; busy exactly W+1 cycles.
REQ-034 rst_n=0 at conversion cycle 4 -> outputs reset per REQ-025; display shows "0" afterwards, not captured value.
REQ-035 SCAN_DIV=4, N_DIG=4 -> each anode low for exactly 4 cycles, order bit0..bit3, one-hot throughout.
